// File: rtl/mux_2to1_flit.sv
// Two-input flit multiplexer with a registered output stage.
// Port choice comes from sel[1:0]; invalid or unselected cycles hold data.
module mux_2to1_flit #(
  parameter int DATAW_P1 = 66,
  parameter int VCHW_P1  = 2,
  parameter int PORT_P1  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATAW_P1-1:0] idata_0,
  input  logic                ivalid_0,
  input  logic [VCHW_P1-1:0]  ivch_0,
  input  logic [DATAW_P1-1:0] idata_1,
  input  logic                ivalid_1,
  input  logic [VCHW_P1-1:0]  ivch_1,
  input  logic [PORT_P1-1:0]  sel,
  output logic [DATAW_P1-1:0] odata,
  output logic                ovalid,
  output logic [VCHW_P1-1:0]  ovch
);

  logic                fwd_valid;
  logic [DATAW_P1-1:0] fwd_data;
  logic [VCHW_P1-1:0]  fwd_vch;
  logic                pick_0;
  logic                pick_1;

  // Upper select bits belong to other ports of the router and are ignored.
  assign pick_0 = (sel[1:0] == 2'b01);
  assign pick_1 = (sel[1:0] == 2'b10);

  always_comb begin
    fwd_valid = 1'b0;
    fwd_data  = idata_0;
    fwd_vch   = ivch_0;
    unique case (1'b1)
      pick_0: begin
        fwd_valid = ivalid_0;
        fwd_data  = idata_0;
        fwd_vch   = ivch_0;
      end
      pick_1: begin
        fwd_valid = ivalid_1;
        fwd_data  = idata_1;
        fwd_vch   = ivch_1;
      end
      default: begin
        fwd_valid = 1'b0;
      end
    endcase
  end

  // Data and vch only load on a valid flit so the bus stays quiet when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      odata  <= '0;
      ovalid <= 1'b0;
      ovch   <= '0;
    end else begin
      ovalid <= fwd_valid;
      if (fwd_valid) begin
        odata <= fwd_data;
        ovch  <= fwd_vch;
      end
    end
  end

endmodule

// File: tb/tb_mux_2to1_flit.sv
// Randomised and directed checks of mux_2to1_flit against a
// cycle-level reference model.
module tb_mux_2to1_flit;
  localparam int DW = 66;
  localparam int VW = 2;
  localparam int PW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] idata_0;
  logic          ivalid_0;
  logic [VW-1:0] ivch_0;
  logic [DW-1:0] idata_1;
  logic          ivalid_1;
  logic [VW-1:0] ivch_1;
  logic [PW-1:0] sel;
  logic [DW-1:0] odata;
  logic          ovalid;
  logic [VW-1:0] ovch;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] m_data;
  logic          m_valid;
  logic [VW-1:0] m_vch;

  mux_2to1_flit #(.DATAW_P1(DW), .VCHW_P1(VW), .PORT_P1(PW)) dut (
    .clk(clk), .rst(rst),
    .idata_0(idata_0), .ivalid_0(ivalid_0), .ivch_0(ivch_0),
    .idata_1(idata_1), .ivalid_1(ivalid_1), .ivch_1(ivch_1),
    .sel(sel),
    .odata(odata), .ovalid(ovalid), .ovch(ovch)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag,
                          input logic [DW-1:0] act,
                          input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_flit();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  // Model: which port the low select bits name, if any.
  function automatic int chosen(input logic [PW-1:0] s);
    if (s[1:0] == 2'b01) return 0;
    if (s[1:0] == 2'b10) return 1;
    return -1;
  endfunction

  task automatic tick();
    int p;
    @(posedge clk);
    if (rst) begin
      m_data  = '0;
      m_valid = 1'b0;
      m_vch   = '0;
    end else begin
      p = chosen(sel);
      m_valid = 1'b0;
      if (p == 0 && ivalid_0) begin
        m_valid = 1'b1;
        m_data  = idata_0;
        m_vch   = ivch_0;
      end else if (p == 1 && ivalid_1) begin
        m_valid = 1'b1;
        m_data  = idata_1;
        m_vch   = ivch_1;
      end
    end
    #1;
    check_eq("odata", odata, m_data);
    check_eq("ovalid", DW'(ovalid), DW'(m_valid));
    check_eq("ovch", DW'(ovch), DW'(m_vch));
  endtask

  task automatic rand_ports();
    idata_0  = rnd_flit();
    idata_1  = rnd_flit();
    ivch_0   = VW'($urandom);
    ivch_1   = VW'($urandom);
    ivalid_0 = 1'($urandom);
    ivalid_1 = 1'($urandom);
  endtask

  logic [DW-1:0] pat [20];
  logic [DW-1:0] flit_x;
  logic [DW-1:0] tail;
  int run;

  initial begin
    rst = 1'b1;
    sel = 5'b00011;
    rand_ports();
    ivalid_0 = 1'b1;
    ivalid_1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("rst_data", odata, '0);
    end

    // Port-1 packet: head, 20 body words, tail.
    rst = 1'b0;
    sel = 5'b00010;
    pat[0] = DW'(26'h3FFFFE0);
    pat[1] = DW'(26'h00003FF);
    for (int i = 2; i < 20; i++) begin
      logic [25:0] w;
      w = 26'(1) << i;
      pat[i] = DW'((i % 2 == 1) ? ~w : w);
    end
    tail = {2'b10, 32'h0, 32'hDEAD_0004};
    run = 0;
    for (int i = 0; i < 22; i++) begin
      idata_0  = rnd_flit();
      ivalid_0 = 1'($urandom);
      ivch_1   = VW'(i);
      ivalid_1 = 1'b1;
      if (i == 0) idata_1 = {2'b01, 32'h0, 32'h04};
      else if (i == 21) idata_1 = tail;
      else idata_1 = pat[i-1];
      tick();
      if (ovalid) run++;
    end
    check_eq("burst_run", DW'(run), DW'(22));
    check_eq("tail_out", odata, tail);

    // Idle gap on the selected port holds the tail.
    ivalid_1 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      idata_1 = rnd_flit();
      ivch_1  = VW'($urandom);
      tick();
      check_eq("gap_hold", odata, tail);
    end

    // Port 0 single flit with port-1 noise.
    sel      = 5'b00001;
    ivalid_0 = 1'b1;
    idata_0  = {2'b01, 32'h0, 32'h09};
    ivch_0   = 2'b01;
    ivalid_1 = 1'b1;
    idata_1  = rnd_flit();
    tick();
    check_eq("p0_data", odata, {2'b01, 32'h0, 32'h09});
    check_eq("p0_vch", DW'(ovch), DW'(1));
    flit_x = odata;

    // No-port encodings.
    sel = 5'b00011;
    idata_0 = rnd_flit();
    idata_1 = rnd_flit();
    tick();
    check_eq("sel11_hold", odata, flit_x);
    sel = 5'b00000;
    idata_0 = rnd_flit();
    tick();
    check_eq("sel00_valid", DW'(ovalid), DW'(0));
    sel = 5'b11110;
    idata_1 = rnd_flit();
    flit_x = idata_1;
    tick();
    check_eq("sel_hi_ign", odata, flit_x);

    // Back-to-back switch 01 -> 10, no bubble.
    sel = 5'b00001;
    idata_0 = rnd_flit();
    flit_x = idata_0;
    tick();
    check_eq("sw_p0", odata, flit_x);
    sel = 5'b00010;
    idata_1 = rnd_flit();
    flit_x = idata_1;
    tick();
    check_eq("sw_p1", odata, flit_x);
    check_eq("sw_valid", DW'(ovalid), DW'(1));

    // Random traffic with occasional mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      rand_ports();
      sel = PW'($urandom_range(0, 31));
      rst = ($urandom_range(0, 29) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
